kmu_result_stage: RTL and testbench
===================================

# kmu_result_stage

Registered output stage directly downstream of the ZBKB bit-manipulation unit in the KMU (crypto) datapath. It captures the combinational ZBKB result with its destination register and W-op flag, and applies RV64 W-type sign-extension. It buffers up to two results in a skid FIFO and presents them to the writeback mux with a valid/ready handshake. It absorbs back-pressure from writeback without stalling the combinational KMU logic mid-cycle, and supports a pipeline flush.

## Interface
- WIDTH, 32: datapath width (XLEN); legal values 32, 64.
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- InValid  in  1  ZBKB result valid this cycle.
- InReady  out  1  stage can accept; registered, equals (Count < 2).
- ZBKBResult  in  WIDTH  combinational result from the ZBKB unit.
- InRd  in  5  destination register index.
- InWOp  in  1  W-type op (packw); sign-extend bit 31 when WIDTH=64, ignored when WIDTH=32.
- FlushE  in  1  discard all buffered and incoming results.
- OutValid  out  1  head entry valid.
- OutReady  in  1  writeback accepts head entry.
- OutResult  out  WIDTH  head entry result.
- OutRd  out  5  head entry destination.
- Count  out  2  occupancy, 0..2.

## Operation
- Accept occurs when InValid && InReady && !FlushE. Output handshake occurs when OutValid && OutReady.
- Rd filter: an accepted transfer with InRd==0 is consumed, but nothing is enqueued and Count is unchanged.
- W-op: when WIDTH=64 and InWOp=1, the stored result is {{32{ZBKBResult[31]}}, ZBKBResult[31:0]}. Otherwise the result is stored unmodified.
- Storage: 2-entry circular FIFO. Read pointer, write pointer and Count are registered. Pointers are 1 bit and wrap 1→0.
- Ordering: strict FIFO; outputs leave in acceptance order.
- Full (Count=2): InReady=0 for the whole cycle, even if a dequeue happens in the same cycle. No enqueue occurs.
- Empty (Count=0): OutValid=0. OutResult and OutRd hold their last value and must not be interpreted.
- Simultaneous enqueue and dequeue at Count=1: Count stays 1 and the pointers both advance.
- FlushE=1: on the next edge Count←0 and both pointers←0. The same-cycle input is not accepted. A same-cycle output handshake is permitted but has no further effect.
- Reset: asynchronous to clk. Count=0, pointers=0, OutValid=0, InReady=1, OutResult=0, OutRd=0. Reset mid-operation drops all entries immediately.

## Timing
- Latency: 1 cycle. A result accepted at edge N is visible on OutValid/OutResult after edge N. There is no combinational in→out bypass.
- Throughput: 1 result per cycle when OutReady stays high (Count oscillates at 1).
- InReady, OutValid, OutResult, OutRd and Count are functions of registers only. There are no combinational paths from inputs to outputs.
- FlushE has priority over enqueue, dequeue and the Rd filter.

## Structure
- Package kmu_pkg holds:
  - `kmu_res_t`: packed struct {logic [XLEN-1:0] result; logic [4:0] rd}.
  - constants `KMU_RES_DEPTH=2` and `KMU_RD_ZERO=5'd0`.
- Sub-module kmu_fifo2: a generic 2-entry FIFO with flush and async active-low reset, parameterized on entry type.
- Sign-extension and the Rd filter are implemented in kmu_result_stage itself.

## Test plan
- Reset, then WIDTH=32, push A=0x1234_5678 (Rd=5) with OutReady=1 → OutValid=1 one cycle later, OutResult=0x1234_5678, OutRd=5, Count=1 then 0.
- WIDTH=64, InWOp=1, ZBKBResult=0x0000_0000_8000_00FF → OutResult=0xFFFF_FFFF_8000_00FF. With InWOp=0 → value unchanged.
- OutReady=0, push 3 results back-to-back (0x11, 0x22, 0x33) → InReady drops after 2 accepts, Count=2, third not accepted. Raise OutReady → 0x11 then 0x22 out, then 0x33 is accepted.
- Push with InRd=0 → InReady stays 1, Count stays 0, OutValid never asserts.
- Count=2 with FlushE=1 and InValid=1 (0x44) → next cycle Count=0, OutValid=0, and 0x44 never appears.
- Deassert reset_n mid-cycle with Count=2 → outputs go to reset values immediately, with no clk edge required.

Source files
------------

// File: rtl/kmu_pkg.sv
// Shared types and constants for the KMU result stage.
// Entries are sized for the widest XLEN; narrower instances zero-fill the upper bits.
package kmu_pkg;

    localparam int         XLEN          = 64;
    localparam int         KMU_RES_DEPTH = 2;
    localparam logic [4:0] KMU_RD_ZERO   = 5'd0;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
    } kmu_res_t;

endpackage

// File: rtl/kmu_result_stage_if.sv
// Bundle between the ZBKB unit, the result stage and the writeback mux.
// Both sides use valid/ready: a transfer happens on the rising edge where valid and ready are both high; valid must not depend on ready.
interface kmu_result_stage_if #(parameter int WIDTH = 32);

    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] ZBKBResult;
    logic [4:0]       InRd;
    logic             InWOp;
    logic             FlushE;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] OutResult;
    logic [4:0]       OutRd;
    logic [1:0]       Count;

    modport slave (
        input  InValid, ZBKBResult, InRd, InWOp, FlushE, OutReady,
        output InReady, OutValid, OutResult, OutRd, Count
    );

    modport master (
        output InValid, ZBKBResult, InRd, InWOp, FlushE, OutReady,
        input  InReady, OutValid, OutResult, OutRd, Count
    );

endinterface

// File: rtl/kmu_fifo2.sv
// Generic 2-entry circular FIFO with synchronous flush and async active-low reset.
// Every output is a function of registers only, so nothing combinational reaches the ports.
module kmu_fifo2
    import kmu_pkg::*;
#(
    parameter type T = kmu_res_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_flush,
    input  logic       i_push,
    input  T           i_data,
    output logic       o_ready,
    output logic       o_valid,
    input  logic       i_ready,
    output T           o_data,
    output logic [1:0] o_count
);

    localparam logic [1:0] FULL = 2'(KMU_RES_DEPTH);

    T           r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    // Full blocks the whole cycle even when a pop frees a slot at the same edge.
    assign o_ready = (r_count < FULL);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    assign w_push = i_push && o_ready && !i_flush;
    assign w_pop  = o_valid && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/kmu_result_stage.sv
// Registered output stage behind the ZBKB unit: W-op sign extension, x0 write filter,
// and a 2-deep skid FIFO toward writeback.
module kmu_result_stage
    import kmu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    kmu_result_stage_if.slave bus
);

    kmu_res_t        w_in_entry;
    kmu_res_t        w_head;
    logic [XLEN-1:0] w_ext_result;
    logic            w_push;
    logic            w_ready;
    logic            w_valid;
    logic [1:0]      w_count;
    logic            w_unused_bits;

    // packw on RV64 yields a 32-bit value that must be sign-extended from bit 31.
    always_comb begin
        w_ext_result = XLEN'(bus.ZBKBResult);
        if (WIDTH == 64 && bus.InWOp) begin
            w_ext_result = {{32{bus.ZBKBResult[31]}}, bus.ZBKBResult[31:0]};
        end
    end

    assign w_in_entry = '{result: w_ext_result, rd: bus.InRd};

    // Writes to x0 are consumed by the handshake but never enqueued; flush and
    // the ready gate are applied inside the FIFO.
    assign w_push = bus.InValid && (bus.InRd != KMU_RD_ZERO);

    kmu_fifo2 #(
        .T (kmu_res_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_flush (bus.FlushE),
        .i_push  (w_push),
        .i_data  (w_in_entry),
        .o_ready (w_ready),
        .o_valid (w_valid),
        .i_ready (bus.OutReady),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign bus.InReady   = w_ready;
    assign bus.OutValid  = w_valid;
    assign bus.OutResult = w_head.result[WIDTH-1:0];
    assign bus.OutRd     = w_head.rd;
    assign bus.Count     = w_count;

    // Upper result bits are always zero when WIDTH=32.
    assign w_unused_bits = ^{w_head.result, bus.InWOp};

endmodule

// File: tb/tb_kmu_result_stage.sv
// Bench for kmu_result_stage: a 32-bit instance under a cycle-accurate scoreboard and a
// 64-bit instance for the W-op sign-extension cases.
module tb_kmu_result_stage;

    localparam int W = 37;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    kmu_result_stage_if #(.WIDTH(32)) bus32 ();
    kmu_result_stage_if #(.WIDTH(64)) bus64 ();

    kmu_result_stage #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(bus32));
    kmu_result_stage #(.WIDTH(64)) dut64 (.clk(clk), .reset_n(reset_n), .bus(bus64));

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [1:0] m_count  = 2'd0;

    // Scoreboard: checks every cycle at the falling edge, then advances the model
    // with the transfers that the coming rising edge will perform.
    always @(negedge clk) begin : scoreboard
        logic [W-1:0] head;
        logic         pop;
        if (!reset_n) begin
            m_count = 2'd0;
            exp_q.delete();
        end else begin
            n_checks++;
            if (bus32.InReady !== (m_count != 2'd2)) begin
                n_fail++;
                $display("FAIL sb_in_ready t=%0t got=%b exp=%b", $time, bus32.InReady, (m_count != 2'd2));
            end
            n_checks++;
            if (bus32.Count !== m_count) begin
                n_fail++;
                $display("FAIL sb_count t=%0t got=%0d exp=%0d", $time, bus32.Count, m_count);
            end
            n_checks++;
            if (bus32.OutValid !== (m_count != 2'd0)) begin
                n_fail++;
                $display("FAIL sb_out_valid t=%0t got=%b exp=%b", $time, bus32.OutValid, (m_count != 2'd0));
            end
            pop = (m_count != 2'd0) && bus32.OutReady;
            if (pop) begin
                head = exp_q.pop_front();
                n_checks++;
                if ({bus32.OutRd, bus32.OutResult} !== head) begin
                    n_fail++;
                    $display("FAIL sb_data t=%0t got=%h exp=%h", $time, {bus32.OutRd, bus32.OutResult}, head);
                end
            end
            if (bus32.FlushE) begin
                m_count = 2'd0;
                exp_q.delete();
            end else begin
                if (bus32.InValid && m_count != 2'd2 && bus32.InRd != 5'd0) begin
                    exp_q.push_back({bus32.InRd, bus32.ZBKBResult});
                    m_count++;
                end
                if (pop) m_count--;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus32.InValid    = v;
        bus32.InRd       = rd;
        bus32.ZBKBResult = d;
    endtask

    task automatic test_reset();
        repeat (2) cycle();
        @(negedge clk);
        n_checks++;
        if (bus32.InReady !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=1", bus32.InReady); end
        n_checks++;
        if (bus32.OutValid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", bus32.OutValid); end
        n_checks++;
        if (bus32.Count !== 2'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", bus32.Count); end
        n_checks++;
        if (bus32.OutResult !== 32'h0 || bus32.OutRd !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_out_data got=%h/%0d exp=0/0", bus32.OutResult, bus32.OutRd);
        end
        cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        bus32.OutReady = 1'b1;
        drive32(1'b1, 5'd5, 32'h1234_5678);
        cycle();
        drive32(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (bus32.OutValid !== 1'b1 || bus32.OutResult !== 32'h1234_5678 || bus32.OutRd !== 5'd5 || bus32.Count !== 2'd1) begin
            n_fail++;
            $display("FAIL basic_latency got=v%b %h rd%0d c%0d exp=v1 12345678 rd5 c1",
                     bus32.OutValid, bus32.OutResult, bus32.OutRd, bus32.Count);
        end
        cycle();
        @(negedge clk);
        n_checks++;
        if (bus32.Count !== 2'd0 || bus32.OutValid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain got=c%0d v%b exp=c0 v0", bus32.Count, bus32.OutValid);
        end
        // InWOp has no effect on a 32-bit instance.
        bus32.InWOp = 1'b1;
        drive32(1'b1, 5'd6, 32'h8000_00FF);
        cycle();
        drive32(1'b0, 5'd0, 32'h0);
        bus32.InWOp = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus32.OutResult !== 32'h8000_00FF) begin
            n_fail++;
            $display("FAIL wop32_ignored got=%h exp=800000ff", bus32.OutResult);
        end
        cycle();
    endtask

    task automatic test_wop64();
        logic [63:0] din  [4] = '{64'h0000_0000_8000_00FF, 64'h0000_0000_8000_00FF,
                                   64'hABCD_0000_1234_5678, 64'hABCD_0000_1234_5678};
        logic        wop  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [63:0] dexp [4] = '{64'hFFFF_FFFF_8000_00FF, 64'h0000_0000_8000_00FF,
                                   64'h0000_0000_1234_5678, 64'hABCD_0000_1234_5678};
        bus64.OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus64.InValid    = 1'b1;
            bus64.InRd       = 5'(i + 1);
            bus64.ZBKBResult = din[i];
            bus64.InWOp      = wop[i];
            cycle();
            bus64.InValid = 1'b0;
            bus64.InWOp   = 1'b0;
            @(negedge clk);
            n_checks++;
            if (bus64.OutValid !== 1'b1 || bus64.OutResult !== dexp[i] || bus64.OutRd !== 5'(i + 1)) begin
                n_fail++;
                $display("FAIL wop64_case%0d got=v%b %h rd%0d exp=v1 %h rd%0d",
                         i, bus64.OutValid, bus64.OutResult, bus64.OutRd, dexp[i], i + 1);
            end
            cycle();
        end
    endtask

    task automatic test_backpressure();
        bus32.OutReady = 1'b0;
        drive32(1'b1, 5'd1, 32'h11);
        cycle();
        drive32(1'b1, 5'd2, 32'h22);
        cycle();
        drive32(1'b1, 5'd3, 32'h33);
        repeat (2) cycle();
        @(negedge clk);
        n_checks++;
        if (bus32.InReady !== 1'b0 || bus32.Count !== 2'd2 || bus32.OutResult !== 32'h11) begin
            n_fail++;
            $display("FAIL bp_full got=r%b c%0d %h exp=r0 c2 00000011", bus32.InReady, bus32.Count, bus32.OutResult);
        end
        cycle();
        bus32.OutReady = 1'b1;
        cycle();
        @(negedge clk);
        n_checks++;
        if (bus32.Count !== 2'd1 || bus32.OutResult !== 32'h22) begin
            n_fail++;
            $display("FAIL bp_full_pop_no_push got=c%0d %h exp=c1 00000022", bus32.Count, bus32.OutResult);
        end
        cycle();
        drive32(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (bus32.Count !== 2'd1 || bus32.OutResult !== 32'h33 || bus32.OutRd !== 5'd3) begin
            n_fail++;
            $display("FAIL bp_third got=c%0d %h rd%0d exp=c1 00000033 rd3", bus32.Count, bus32.OutResult, bus32.OutRd);
        end
        cycle();
    endtask

    task automatic test_rd_zero();
        bus32.OutReady = 1'b1;
        drive32(1'b1, 5'd0, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            cycle();
            @(negedge clk);
            n_checks++;
            if (bus32.InReady !== 1'b1 || bus32.Count !== 2'd0 || bus32.OutValid !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_zero_filter got=r%b c%0d v%b exp=r1 c0 v0", bus32.InReady, bus32.Count, bus32.OutValid);
            end
        end
        drive32(1'b0, 5'd0, 32'h0);
        cycle();
    endtask

    task automatic test_flush();
        bus32.OutReady = 1'b0;
        drive32(1'b1, 5'd7, 32'h55);
        cycle();
        drive32(1'b1, 5'd8, 32'h66);
        cycle();
        bus32.FlushE = 1'b1;
        drive32(1'b1, 5'd9, 32'h44);
        @(negedge clk);
        n_checks++;
        if (bus32.Count !== 2'd2) begin n_fail++; $display("FAIL flush_pre_full got=%0d exp=2", bus32.Count); end
        cycle();
        bus32.FlushE = 1'b0;
        drive32(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (bus32.Count !== 2'd0 || bus32.OutValid !== 1'b0 || bus32.InReady !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_clear got=c%0d v%b r%b exp=c0 v0 r1", bus32.Count, bus32.OutValid, bus32.InReady);
        end
        bus32.OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            @(negedge clk);
            n_checks++;
            if (bus32.OutValid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_no_output got=v%b %h exp=v0", bus32.OutValid, bus32.OutResult);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus32.OutReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive32(1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i));
            cycle();
            @(negedge clk);
            n_checks++;
            if (bus32.Count !== 2'd1 || bus32.OutResult !== 32'hA000_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL b2b_stream%0d got=c%0d %h exp=c1 %h", i, bus32.Count, bus32.OutResult, 32'hA000_0000 + 32'(i));
            end
        end
        for (int i = 0; i < 60; i++) begin
            drive32($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom);
            bus32.OutReady = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drive32(1'b0, 5'd0, 32'h0);
        bus32.OutReady = 1'b1;
        repeat (4) cycle();
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || bus32.Count !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_drain got=c%0d q%0d exp=c0 q0", bus32.Count, exp_q.size());
        end
        cycle();
    endtask

    task automatic test_async_reset();
        bus32.OutReady = 1'b0;
        drive32(1'b1, 5'd10, 32'hA1);
        cycle();
        drive32(1'b1, 5'd11, 32'hA2);
        cycle();
        drive32(1'b0, 5'd0, 32'h0);
        #2;
        n_checks++;
        if (bus32.Count !== 2'd2) begin n_fail++; $display("FAIL arst_pre_full got=%0d exp=2", bus32.Count); end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus32.Count !== 2'd0 || bus32.OutValid !== 1'b0 || bus32.InReady !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_ctrl got=c%0d v%b r%b exp=c0 v0 r1", bus32.Count, bus32.OutValid, bus32.InReady);
        end
        n_checks++;
        if (bus32.OutResult !== 32'h0 || bus32.OutRd !== 5'd0) begin
            n_fail++;
            $display("FAIL arst_data got=%h rd%0d exp=0 rd0", bus32.OutResult, bus32.OutRd);
        end
        cycle();
        reset_n = 1'b1;
        cycle();
    endtask

    initial begin
        bus32.InValid = 1'b0; bus32.ZBKBResult = '0; bus32.InRd = 5'd0;
        bus32.InWOp = 1'b0; bus32.FlushE = 1'b0; bus32.OutReady = 1'b0;
        bus64.InValid = 1'b0; bus64.ZBKBResult = '0; bus64.InRd = 5'd0;
        bus64.InWOp = 1'b0; bus64.FlushE = 1'b0; bus64.OutReady = 1'b0;

        test_reset();
        test_basic();
        test_wop64();
        test_backpressure();
        test_rd_zero();
        test_flush();
        test_back_to_back();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
